// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the queue entry layout and the fetch FSM states.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR    = 16'h0000;
  localparam int          DEF_QDEPTH   = 4;
  localparam int          DEF_MAX_OUT  = 2;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_imem_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// The requester is the master, the memory is the slave.
interface fetch_imem_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_queue.sv
// QDEPTH-entry FIFO of {instr, pc} with a single-cycle flush.
// The head entry is read combinationally from registered storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  fetch_entry_t              i_push_entry,
  input  logic                      i_pop,
  output fetch_entry_t              o_head,
  output logic [$clog2(QDEPTH):0]   o_count
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_entry_t   r_mem [QDEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic           w_wr;
  logic           w_rd;

  // Flush overrides both ends, so a flushed cycle never writes or reads.
  assign w_wr = i_push && !i_flush;
  assign w_rd = i_pop && !i_flush && (r_count != '0);

  // NOTE: the storage array carries no reset; head/tail/count are reset, so
  // an empty queue never exposes whatever the array happens to hold.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_tail] <= i_push_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_rd) begin
        r_head <= r_head + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

  overflow_a : assert property (@(posedge clk) disable iff (reset)
    !(i_push && !i_pop && !i_flush && (r_count == CW'(QDEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited imem requests, in-order responses
// buffered in fetch_queue, redirect flushes and drains in-flight responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          QDEPTH   = DEF_QDEPTH,
  parameter int          MAX_OUT  = DEF_MAX_OUT,
  parameter logic [15:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 is_branch_taken,
  input  logic [15:0]          branch_target,
  fetch_imem_if.master         imem_bus,
  output logic [15:0]          instr,
  output logic [15:0]          instr_pc,
  output logic                 instr_valid
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  fetch_state_e  r_state;
  fetch_state_e  w_state_next;
  logic [15:0]   r_pc;
  logic [15:0]   r_resp_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] w_out_drop;
  logic [OW-1:0] w_out_next;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_credit;
  logic          w_req;
  logic          w_accept;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp      = imem_bus.imem_rvalid && (r_outstanding != '0);
  assign w_out_drop = r_outstanding - OW'(w_rsp);
  assign w_credit   = (32'(r_outstanding) < MAX_OUT) &&
                      ((32'(w_count) + 32'(r_outstanding)) < QDEPTH);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      FETCH: begin
        w_req  = !reset && !is_branch_taken && w_credit;
        w_push = w_rsp && !is_branch_taken;
        if (is_branch_taken && (w_out_drop != '0)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_out_drop == '0) begin
          w_state_next = FETCH;
        end
      end
      default: w_state_next = FETCH;
    endcase
  end

  assign w_accept     = w_req && imem_bus.imem_ready;
  assign w_out_next   = w_out_drop + OW'(w_accept);
  assign w_pop        = instr_valid && !stall && !is_branch_taken;
  assign w_push_entry = '{instr: imem_bus.imem_rdata, pc: r_resp_pc};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      if (is_branch_taken) begin
        r_pc      <= branch_target;
        r_resp_pc <= branch_target;
      end else begin
        if (w_accept) begin
          r_pc <= r_pc + 16'd1;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 16'd1;
        end
      end
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (is_branch_taken),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  assign imem_bus.imem_req  = w_req;
  assign imem_bus.imem_addr = r_pc;
  assign instr_valid        = (w_count != '0);
  assign instr              = instr_valid ? w_head.instr : NOP_INSTR;
  assign instr_pc           = instr_valid ? w_head.pc : 16'h0000;

  stray_rsp_a : assert property (@(posedge clk) disable iff (reset)
    !(imem_bus.imem_rvalid && (r_outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: 1-cycle-latency memory model returning
// 16'h1000+addr, with a hold switch to keep responses in flight.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        is_branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;

  fetch_imem_if imem_bus ();

  fetch_unit #(
    .QDEPTH   (4),
    .MAX_OUT  (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .is_branch_taken (is_branch_taken),
    .branch_target   (branch_target),
    .imem_bus        (imem_bus),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic        mem_hold = 1'b0;
  logic [15:0] mem_q[$];
  logic [15:0] exp_pc;

  // Memory: answers one cycle after acceptance, in order, unless held.
  always @(negedge clk) begin
    if (reset) begin
      mem_q.delete();
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = 16'h0000;
    end else begin
      if (!mem_hold && mem_q.size() > 0) begin
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = 16'h1000 + mem_q.pop_front();
      end else begin
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 16'h0000;
      end
      if (imem_bus.imem_req && imem_bus.imem_ready) begin
        mem_q.push_back(imem_bus.imem_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: instr_valid=%b after %0d cycles, want 1", tag, instr_valid, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    is_branch_taken = 1'b0;
    branch_target = 16'h0000;
    mem_hold = 1'b0;
    imem_bus.imem_ready = 1'b1;
    repeat (3) tick();
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", instr_pc); end
    checks++; if (imem_bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", imem_bus.imem_addr); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b want 0", instr_valid); end
    checks++; if (imem_bus.imem_addr !== 16'h0001) begin errors++; $display("FAIL stream_addr: got %h want 0001", imem_bus.imem_addr); end
    tick();
    exp_pc = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, instr_valid); end
      checks++; if (instr !== 16'h1000 + exp_pc) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr, 16'h1000 + exp_pc); end
      checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, instr_pc, exp_pc); end
      tick();
      exp_pc++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stall_pc[%0d]: got %h want %h", i, instr_pc, exp_pc); end
      checks++; if (instr !== 16'h1000 + exp_pc) begin errors++; $display("FAIL stall_instr[%0d]: got %h want %h", i, instr, 16'h1000 + exp_pc); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
    end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_full_req: got %b want 0", imem_bus.imem_req); end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL resume_valid[%0d]: got %b want 1", i, instr_valid); end
      checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL resume_pc[%0d]: got %h want %h", i, instr_pc, exp_pc); end
      checks++; if (instr !== 16'h1000 + exp_pc) begin errors++; $display("FAIL resume_instr[%0d]: got %h want %h", i, instr, 16'h1000 + exp_pc); end
      tick();
      exp_pc++;
    end
  endtask

  task automatic test_redirect();
    mem_hold = 1'b1;
    repeat (3) tick();
    is_branch_taken = 1'b1;
    branch_target = 16'h0040;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_req: got %b want 0", imem_bus.imem_req); end
    tick();
    is_branch_taken = 1'b0;
    mem_hold = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL redir_instr: got %h want 0000", instr); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL redir_pc: got %h want 0000", instr_pc); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL drain_req0: got %b want 0", imem_bus.imem_req); end
    tick();
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL drain_req1: got %b want 0", imem_bus.imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", instr_valid); end
    tick();
    checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL refetch_req: got %b want 1", imem_bus.imem_req); end
    checks++; if (imem_bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL refetch_addr: got %h want 0040", imem_bus.imem_addr); end
    wait_valid("redir");
    checks++; if (instr_pc !== 16'h0040) begin errors++; $display("FAIL redir_new_pc: got %h want 0040", instr_pc); end
    checks++; if (instr !== 16'h1040) begin errors++; $display("FAIL redir_new_instr: got %h want 1040", instr); end
    tick();
    checks++; if (instr_pc !== 16'h0041) begin errors++; $display("FAIL redir_next_pc: got %h want 0041", instr_pc); end
  endtask

  task automatic test_flush_priority();
    stall = 1'b1;
    is_branch_taken = 1'b1;
    branch_target = 16'h0080;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL prio_req: got %b want 0", imem_bus.imem_req); end
    tick();
    is_branch_taken = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL prio_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL prio_instr: got %h want 0000", instr); end
    checks++; if (imem_bus.imem_addr !== 16'h0080) begin errors++; $display("FAIL prio_addr: got %h want 0080", imem_bus.imem_addr); end
    wait_valid("prio");
    checks++; if (instr_pc !== 16'h0080) begin errors++; $display("FAIL prio_new_pc: got %h want 0080", instr_pc); end
    checks++; if (instr !== 16'h1080) begin errors++; $display("FAIL prio_new_instr: got %h want 1080", instr); end
    repeat (2) tick();
    checks++; if (instr_pc !== 16'h0080) begin errors++; $display("FAIL prio_hold_pc: got %h want 0080", instr_pc); end
    stall = 1'b0;
    tick();
    checks++; if (instr_pc !== 16'h0081) begin errors++; $display("FAIL prio_resume_pc: got %h want 0081", instr_pc); end
  endtask

  task automatic test_wrap();
    logic [15:0] want_pc [4];
    logic [15:0] want_in [4];
    want_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    want_in = '{16'h0FFE, 16'h0FFF, 16'h1000, 16'h1001};
    is_branch_taken = 1'b1;
    branch_target = 16'hFFFE;
    tick();
    is_branch_taken = 1'b0;
    wait_valid("wrap");
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_pc !== want_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, instr_pc, want_pc[i]); end
      checks++; if (instr !== want_in[i]) begin errors++; $display("FAIL wrap_instr[%0d]: got %h want %h", i, instr, want_in[i]); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", instr_valid); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL areset_req: got %b want 0", imem_bus.imem_req); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL areset_instr: got %h want 0000", instr); end
    checks++; if (imem_bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL areset_addr: got %h want 0000", imem_bus.imem_addr); end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL areset_first_valid: got %b want 0", instr_valid); end
    wait_valid("areset");
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL areset_pc: got %h want 0000", instr_pc); end
    checks++; if (instr !== 16'h1000) begin errors++; $display("FAIL areset_instr_new: got %h want 1000", instr); end
    tick();
    checks++; if (instr_pc !== 16'h0001) begin errors++; $display("FAIL areset_next_pc: got %h want 0001", instr_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_flush_priority();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: QDEPTH, 4, instruction queue entries (power of 2, >=2).
REQ-002 MAX_OUT, 2, maximum outstanding imem requests (>=1).
REQ-003 RESET_PC, 16'h0000, PC loaded at reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 stall  in  1  decode cannot accept; hold instr/instr_pc/instr_valid.
REQ-007 is_branch_taken  in  1  redirect: flush and refetch from branch_target.
REQ-008 branch_target  in  16  redirect PC, sampled only when is_branch_taken=1.
REQ-009 imem_req  out  1  fetch request valid.
REQ-010 imem_addr  out  16  word address of request (= fetch PC).
REQ-011 imem_ready  in  1  request accepted when imem_req&&imem_ready.
REQ-012 imem_rvalid  in  1  response valid; in-order, one per accepted request.
REQ-013 imem_rdata  in  16  response instruction word.
REQ-014 instr  out  16  instruction to decode; 16'h0000 (NOP) when instr_valid=0.
REQ-015 instr_pc  out  16  PC of instr; 16'h0000 when instr_valid=0.
REQ-016 instr_valid  out  1  instr holds a real instruction.

Function
REQ-017 Word addressing: fetch PC SHALL increment by 1 per accepted request, wrapping 16'hFFFF->16'h0000.
REQ-018 FSM SHALL have states FETCH and DRAIN; reset enters FETCH.
REQ-019 In FETCH, imem_req=1 iff outstanding<MAX_OUT and occupancy+outstanding<QDEPTH; otherwise 0.
REQ-020 In DRAIN, imem_req SHALL be 0; every imem_rvalid SHALL be discarded and decrement outstanding.
REQ-021 DRAIN->FETCH when outstanding==0 (after counting that cycle's discarded response); FETCH->DRAIN on redirect with outstanding (after that cycle's accepted request) >0, else stay FETCH.
REQ-022 In FETCH, imem_rvalid SHALL push {imem_rdata, pc} into the queue; data visible on instr the next cycle if queue was empty.
REQ-023 instr/instr_pc SHALL be the queue head combinationally from registered storage; instr_valid = occupancy!=0.
REQ-024 Pop SHALL occur when instr_valid && !stall; push and pop in the same cycle are legal at any occupancy, occupancy unchanged.
REQ-025 Credit rule SHALL guarantee no push to a full queue; an rvalid with no outstanding request is a protocol error (assertion, no state change).
REQ-026 Redirect (is_branch_taken=1) SHALL have priority over stall, push and pop: queue flushed, fetch PC <= branch_target, rvalid in that cycle discarded, imem_req forced 0 that cycle.
REQ-027 Redirect during DRAIN SHALL reload fetch PC and remain in DRAIN.
REQ-028 stall SHALL not block fetching; queue fills to QDEPTH then requests stop.
REQ-029 Response PC SHALL be tracked by a PC FIFO or response-PC counter reset to the fetch PC on redirect.

Reset
REQ-030 On reset: fetch PC=RESET_PC, occupancy=0, outstanding=0, state FETCH, imem_req=0 while reset high, instr=16'h0000, instr_pc=16'h0000, instr_valid=0.
REQ-031 Reset mid-operation SHALL abandon outstanding requests; late responses after reset deassertion are the memory's responsibility not to send.

Structure
REQ-032 Package fetch_pkg SHALL hold NOP_INSTR=16'h0000, default QDEPTH/MAX_OUT/RESET_PC, and the FSM state enum.
REQ-033 One sub-module fetch_queue (QDEPTH-entry FIFO of {instr,pc}, flush input) SHALL hold the instruction buffer.

Verification
REQ-034 Reset then imem_ready=1, 1-cycle response latency, rdata=16'h1000+addr, no stall -> instr_valid from cycle 3, instr 16'h1000,16'h1001,... with instr_pc 0,1,....
REQ-035 stall=1 for 10 cycles mid-stream -> instr/instr_pc frozen; imem_req drops after queue holds 4 and outstanding 0; stream resumes without loss or duplication.
REQ-036 is_branch_taken=1 with branch_target=16'h0040 while 2 requests outstanding -> next cycle instr_valid=0, instr=16'h0000; two responses discarded in DRAIN; first new instr_pc=16'h0040.
REQ-037 Redirect coincident with stall and imem_rvalid -> flush wins; that response never appears on instr.
REQ-038 branch_target=16'hFFFE, free-running -> instr_pc sequence FFFE, FFFF, 0000, 0001.
REQ-039 Reset asserted asynchronously mid-stream (between edges) -> instr_valid=0, imem_req=0 immediately; after release fetching restarts at 16'h0000.
